// File: rtl/life_step_sched_pkg.sv
// Shared types and constants for the Life generation-step scheduler.
// The divider bus width is shared with the free-running clock divider.
package life_step_sched_pkg;

    localparam int DIV_W        = 32;
    localparam int BASE_TAP_DEF = 24;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        REQ     = 2'd2
    } state_t;

endpackage

// File: rtl/tap_edge_det.sv
// Divider tap select and rising-edge detect for the step scheduler.
// A speed change masks the edge for one cycle while the history reloads.
module tap_edge_det
    import life_step_sched_pkg::*;
#(
    parameter int BASE_TAP = BASE_TAP_DEF,
    parameter int SPEED_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   clkdiv,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    localparam int IW = $clog2(DIV_W);

    logic [IW-1:0]      idx;
    logic               sel;
    logic               sel_q;
    logic [SPEED_W-1:0] speed_q;
    logic               spd_chg;

    assign idx     = IW'(BASE_TAP) - IW'(speed);
    assign sel     = clkdiv[idx];
    assign spd_chg = (speed != speed_q);
    assign tick    = sel & ~sel_q & ~spd_chg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= 1'b0;
            speed_q <= '0;
        end else begin
            sel_q   <= sel;
            speed_q <= speed;
        end
    end

endmodule

// File: rtl/life_step_sched.sv
// Generation-step scheduler: turns divider ticks or manual steps into
// held step requests, counts completed generations, flags overruns.
module life_step_sched
    import life_step_sched_pkg::*;
#(
    parameter int BASE_TAP = BASE_TAP_DEF,
    parameter int SPEED_W  = 3,
    parameter int GEN_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   clkdiv,
    input  logic [SPEED_W-1:0] speed,
    input  logic               run_tog,
    input  logic               step,
    input  logic               ovr_clr,
    input  logic               step_ack,
    output logic               step_req,
    output logic               running,
    output logic [GEN_W-1:0]   gen_count,
    output logic               overrun
);

    state_t             state;
    state_t             state_n;
    logic               tick;
    logic               req_n;
    logic               running_n;
    logic               overrun_n;
    logic [GEN_W-1:0]   gen_n;

    tap_edge_det #(
        .BASE_TAP (BASE_TAP),
        .SPEED_W  (SPEED_W)
    ) u_tap (
        .clk    (clk),
        .rst    (rst),
        .clkdiv (clkdiv),
        .speed  (speed),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PAUSED;
            step_req  <= 1'b0;
            running   <= 1'b0;
            gen_count <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            step_req  <= req_n;
            running   <= running_n;
            gen_count <= gen_n;
            overrun   <= overrun_n;
        end
    end

    // REQ always finishes; the return mode follows any toggle seen meanwhile
    always_comb begin
        state_n = state;
        unique case (state)
            PAUSED: begin
                if (run_tog)   state_n = RUNNING;
                else if (step) state_n = REQ;
            end
            RUNNING: begin
                if (run_tog)   state_n = PAUSED;
                else if (tick) state_n = REQ;
            end
            REQ: begin
                if (step_ack)
                    state_n = (running ^ run_tog) ? RUNNING : PAUSED;
            end
            default: state_n = PAUSED;
        endcase
    end

    always_comb begin
        req_n     = (state_n == REQ);
        running_n = running ^ run_tog;
        gen_n     = gen_count;
        overrun_n = overrun;
        if (state == REQ && step_ack)
            gen_n = gen_count + 1'b1;
        if (state == REQ && tick)
            overrun_n = 1'b1;
        else if (ovr_clr)
            overrun_n = 1'b0;
    end

endmodule
